// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port unified memory between the IF-stage
// instruction fetch and the MEM-stage data access of an RV32I 5-stage pipeline.
// Data accesses normally win arbitration; a starvation counter forces a fetch
// grant after STARVE_LIMIT consecutive data grants with a fetch waiting.
// Optional build macro: MEM_ARBITER_PERF_EN adds stall/conflict cycle counters.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef MEM_ARBITER_PERF_EN
    output logic [31:0]           perf_stall_cyc,
    output logic [31:0]           perf_conflict_cyc,
`endif
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_cancel,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_ack,
    output logic                  if_stall,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    input  logic [DATA_W/8-1:0]   dm_wstrb,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  dm_ack,
    output logic                  dm_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_ready,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM,
        DROP
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] starve_cnt;

    logic       if_valid;
    logic       dm_valid;
    logic       starved;
    logic       grant_if;
    logic       grant_dm;
    logic       if_done;
    logic       dm_done;
    logic       mem_done;

    // A request seen in the same cycle as its own ack is the stale, already
    // served one, so it must not be granted a second time.
    assign if_valid = if_req & ~if_cancel & ~if_ack;
    assign dm_valid = dm_req & ~dm_ack;
    assign starved  = (starve_cnt == LIMIT);

    assign if_stall = if_req & ~if_ack & ~if_cancel;
    assign dm_stall = dm_req & ~dm_ack;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration, access sequencing and completion decode
    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_dm  = 1'b0;
        if_done   = 1'b0;
        dm_done   = 1'b0;
        mem_done  = 1'b0;
        case (state)
            IDLE: begin
                if (dm_valid && !(if_valid && starved)) begin
                    grant_dm  = 1'b1;
                    state_nxt = BUSY_DM;
                end else if (if_valid) begin
                    grant_if  = 1'b1;
                    state_nxt = BUSY_IF;
                end
            end
            BUSY_IF: begin
                if (mem_ready) begin
                    mem_done  = 1'b1;
                    if_done   = ~if_cancel;
                    state_nxt = IDLE;
                end else if (if_cancel) begin
                    state_nxt = DROP;
                end
            end
            BUSY_DM: begin
                if (mem_ready) begin
                    mem_done  = 1'b1;
                    dm_done   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DROP: begin
                if (mem_ready) begin
                    mem_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Memory-side request registers, loaded on grant and held until mem_ready
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else if (grant_dm) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_wstrb <= dm_wstrb;
        end else if (grant_if) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else if (mem_done) begin
            mem_req   <= 1'b0;
        end
    end

    // One-cycle acks and read-data capture; stores leave dm_rdata untouched
    always_ff @(posedge clk) begin
        if (!reset) begin
            if_ack   <= 1'b0;
            dm_ack   <= 1'b0;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            if_ack <= if_done;
            dm_ack <= dm_done;
            if (if_done) begin
                if_rdata <= mem_rdata;
            end
            if (dm_done && !mem_we) begin
                dm_rdata <= mem_rdata;
            end
        end
    end

    // Count consecutive data grants that overtook a waiting fetch
    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_if || !if_req) begin
                starve_cnt <= '0;
            end else if (grant_dm && if_valid && (starve_cnt != LIMIT)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

`ifdef MEM_ARBITER_PERF_EN
    // Free-running performance counters for stall and contention cycles
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall_cyc    <= '0;
            perf_conflict_cyc <= '0;
        end else begin
            if (if_stall || dm_stall) begin
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            end
            if ((state == IDLE) && dm_valid && if_valid) begin
                perf_conflict_cyc <= perf_conflict_cyc + 32'd1;
            end
        end
    end
`endif

endmodule
